// File: rtl/fpu_shared_adapter.sv
// Shares one FPU between NB_CH APU request channels: a round-robin issue arbiter
// with response credits, and an in-order response FIFO routed back by channel tag.
module fpu_shared_adapter #(
    parameter int NB_CH           = 4,
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int RESP_DEPTH      = 4,
    localparam int CH_BITS        = (NB_CH > 2) ? $clog2(NB_CH) : 1,
    localparam int TAG_W          = CH_BITS + ID_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NB_CH-1:0]                                apu_req_i,
    output logic [NB_CH-1:0]                                apu_gnt_o,
    input  logic [NB_CH-1:0][ID_WIDTH-1:0]                  apu_ID_i,
    input  logic [NB_CH-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]   apu_operands_i,
    input  logic [NB_CH-1:0][OPCODE_WIDTH-1:0]              apu_op_i,
    input  logic [NB_CH-1:0][FLAGS_IN_WIDTH-1:0]            apu_flags_i,
    output logic [NB_CH-1:0]                                apu_rvalid_o,
    input  logic [NB_CH-1:0]                                apu_rready_i,
    output logic [DATA_WIDTH-1:0]                           apu_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]                      apu_rflags_o,
    output logic [ID_WIDTH-1:0]                             apu_rID_o,
    output logic                                            fpu_valid_o,
    input  logic                                            fpu_ready_i,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]              fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                         fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]                       fpu_flags_o,
    output logic [TAG_W-1:0]                                fpu_tag_o,
    input  logic                                            fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                           fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]                      fpu_rflags_i,
    input  logic [TAG_W-1:0]                                fpu_rtag_i,
    output logic                                            busy_o
);

    localparam int PTR_W = (RESP_DEPTH > 2) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CRD_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0]           tag;
        logic [DATA_WIDTH-1:0]      data;
        logic [FLAGS_OUT_WIDTH-1:0] flags;
    } resp_t;

    logic [CH_BITS-1:0] rr_q;
    logic [CH_BITS-1:0] rr_win;
    logic [CH_BITS-1:0] rr_idx;
    logic [CH_BITS-1:0] sel_ch;
    logic               rr_found;
    logic               lock_q;
    logic [CH_BITS-1:0] lock_ch_q;
    logic [CRD_W-1:0]   credit_q;
    logic               issue;

    resp_t              mem_q [RESP_DEPTH];
    resp_t              head;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CH_BITS-1:0] head_ch;
    logic               push;
    logic               pop;

    // Round-robin search starting at rr_q; first requesting channel wins.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < NB_CH; k++) begin
            rr_idx = CH_BITS'((int'(rr_q) + k) % NB_CH);
            if (!rr_found && apu_req_i[rr_idx]) begin
                rr_win   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    // Issue handshake: a transfer happens in a cycle where fpu_valid_o and fpu_ready_i
    // are both high; once valid is shown it is held, with the same channel and payload,
    // until the transfer (the winner is frozen in lock_ch_q while the FPU stalls).
    assign sel_ch      = lock_q ? lock_ch_q : rr_win;
    assign fpu_valid_o = rst_n & (|apu_req_i) & (credit_q < CRD_W'(RESP_DEPTH));
    assign issue       = fpu_valid_o & fpu_ready_i;

    assign apu_gnt_o      = issue ? ({{(NB_CH-1){1'b0}}, 1'b1} << sel_ch) : '0;
    assign fpu_operands_o = fpu_valid_o ? apu_operands_i[sel_ch] : '0;
    assign fpu_op_o       = fpu_valid_o ? apu_op_i[sel_ch] : '0;
    assign fpu_flags_o    = fpu_valid_o ? apu_flags_i[sel_ch] : '0;
    assign fpu_tag_o      = fpu_valid_o ? {sel_ch, apu_ID_i[sel_ch]} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= fpu_valid_o & ~fpu_ready_i;
            lock_ch_q <= sel_ch;
            if (issue) begin
                rr_q <= (sel_ch == CH_BITS'(NB_CH - 1)) ? '0 : sel_ch + 1'b1;
            end
        end
    end

    // Credits cover both in-flight operations and buffered responses, so the FIFO cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else if (issue && !pop) begin
            credit_q <= credit_q + 1'b1;
        end else if (!issue && pop) begin
            credit_q <= credit_q - 1'b1;
        end
    end

    assign busy_o = (credit_q != '0);

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(RESP_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign head_ch    = head.tag[TAG_W-1:ID_WIDTH];
    assign push       = fpu_rvalid_i;
    assign pop        = |(apu_rvalid_o & apu_rready_i);

    assign apu_rvalid_o = fifo_empty ? '0 : ({{(NB_CH-1){1'b0}}, 1'b1} << head_ch);
    assign apu_rdata_o  = fifo_empty ? '0 : head.data;
    assign apu_rflags_o = fifo_empty ? '0 : head.flags;
    assign apu_rID_o    = fifo_empty ? '0 : head.tag[ID_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{tag: fpu_rtag_i, data: fpu_rdata_i, flags: fpu_rflags_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule
